adder_axi_kernel: RTL

Parametrised vector-add kernel for the SDAccel shell. It replaces the tied-off adder stub with a working datapath. Software programs source and destination buffers, a beat count and a 32-bit addend through the AXI-lite slave (s0), then starts the kernel. The kernel reads the source over the AXI4 master (m0) in INCR bursts, adds the addend to every lane, and writes the result to the destination.

---
 rtl/adder_axi_kernel_if.sv | 127 ++++++++++++
 rtl/adder_axi_kernel.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_axi_kernel_if.sv
// Bus bundles for adder_axi_kernel: an AXI4 master port (m0) and an
// AXI-lite slave port (s0). Field names follow the shell's io_m0_* / io_s0_*
// naming with the channel prefix moved into the interface instance.

interface adder_axi_kernel_m0_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 64
);
  // AW
  logic              writeAddr_valid;
  logic              writeAddr_ready;
  logic [ADDR_W-1:0] writeAddr_bits_addr;
  logic [2:0]        writeAddr_bits_size;
  logic [7:0]        writeAddr_bits_len;
  logic [1:0]        writeAddr_bits_burst;
  logic              writeAddr_bits_id;
  logic              writeAddr_bits_lock;
  logic [3:0]        writeAddr_bits_cache;
  logic [2:0]        writeAddr_bits_prot;
  logic [3:0]        writeAddr_bits_qos;
  // W
  logic              writeData_valid;
  logic              writeData_ready;
  logic [DATA_W-1:0] writeData_bits_data;
  logic [DATA_W/8-1:0] writeData_bits_strb;
  logic              writeData_bits_last;
  // B
  logic              writeResp_ready;
  logic              writeResp_valid;
  logic              writeResp_bits_id;
  logic [1:0]        writeResp_bits_resp;
  // AR
  logic              readAddr_valid;
  logic              readAddr_ready;
  logic [ADDR_W-1:0] readAddr_bits_addr;
  logic [2:0]        readAddr_bits_size;
  logic [7:0]        readAddr_bits_len;
  logic [1:0]        readAddr_bits_burst;
  logic              readAddr_bits_id;
  logic              readAddr_bits_lock;
  logic [3:0]        readAddr_bits_cache;
  logic [2:0]        readAddr_bits_prot;
  logic [3:0]        readAddr_bits_qos;
  // R
  logic              readData_ready;
  logic              readData_valid;
  logic [DATA_W-1:0] readData_bits_data;
  logic              readData_bits_id;
  logic              readData_bits_last;
  logic [1:0]        readData_bits_resp;

  modport master (
    output writeAddr_valid, writeAddr_bits_addr, writeAddr_bits_size, writeAddr_bits_len,
           writeAddr_bits_burst, writeAddr_bits_id, writeAddr_bits_lock, writeAddr_bits_cache,
           writeAddr_bits_prot, writeAddr_bits_qos,
    input  writeAddr_ready,
    output writeData_valid, writeData_bits_data, writeData_bits_strb, writeData_bits_last,
    input  writeData_ready,
    output writeResp_ready,
    input  writeResp_valid, writeResp_bits_id, writeResp_bits_resp,
    output readAddr_valid, readAddr_bits_addr, readAddr_bits_size, readAddr_bits_len,
           readAddr_bits_burst, readAddr_bits_id, readAddr_bits_lock, readAddr_bits_cache,
           readAddr_bits_prot, readAddr_bits_qos,
    input  readAddr_ready,
    output readData_ready,
    input  readData_valid, readData_bits_data, readData_bits_id, readData_bits_last,
           readData_bits_resp
  );

  modport slave (
    input  writeAddr_valid, writeAddr_bits_addr, writeAddr_bits_size, writeAddr_bits_len,
           writeAddr_bits_burst, writeAddr_bits_id, writeAddr_bits_lock, writeAddr_bits_cache,
           writeAddr_bits_prot, writeAddr_bits_qos,
    output writeAddr_ready,
    input  writeData_valid, writeData_bits_data, writeData_bits_strb, writeData_bits_last,
    output writeData_ready,
    input  writeResp_ready,
    output writeResp_valid, writeResp_bits_id, writeResp_bits_resp,
    input  readAddr_valid, readAddr_bits_addr, readAddr_bits_size, readAddr_bits_len,
           readAddr_bits_burst, readAddr_bits_id, readAddr_bits_lock, readAddr_bits_cache,
           readAddr_bits_prot, readAddr_bits_qos,
    output readAddr_ready,
    input  readData_ready,
    output readData_valid, readData_bits_data, readData_bits_id, readData_bits_last,
           readData_bits_resp
  );
endinterface

interface adder_axi_kernel_s0_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              writeAddr_ready;
  logic              writeAddr_valid;
  logic [ADDR_W-1:0] writeAddr_bits_addr;
  logic [2:0]        writeAddr_bits_prot;
  logic              writeData_ready;
  logic              writeData_valid;
  logic [31:0]       writeData_bits_data;
  logic [3:0]        writeData_bits_strb;
  logic              writeResp_ready;
  logic              writeResp_valid;
  logic [1:0]        writeResp_bits;
  logic              readAddr_ready;
  logic              readAddr_valid;
  logic [ADDR_W-1:0] readAddr_bits_addr;
  logic [2:0]        readAddr_bits_prot;
  logic              readData_ready;
  logic              readData_valid;
  logic [31:0]       readData_bits_data;
  logic [1:0]        readData_bits_resp;

  modport master (
    input  writeAddr_ready, writeData_ready, writeResp_valid, writeResp_bits,
           readAddr_ready, readData_valid, readData_bits_data, readData_bits_resp,
    output writeAddr_valid, writeAddr_bits_addr, writeAddr_bits_prot,
           writeData_valid, writeData_bits_data, writeData_bits_strb, writeResp_ready,
           readAddr_valid, readAddr_bits_addr, readAddr_bits_prot, readData_ready
  );

  modport slave (
    output writeAddr_ready, writeData_ready, writeResp_valid, writeResp_bits,
           readAddr_ready, readData_valid, readData_bits_data, readData_bits_resp,
    input  writeAddr_valid, writeAddr_bits_addr, writeAddr_bits_prot,
           writeData_valid, writeData_bits_data, writeData_bits_strb, writeResp_ready,
           readAddr_valid, readAddr_bits_addr, readAddr_bits_prot, readData_ready
  );
endinterface

// File: rtl/adder_axi_kernel.sv
// adder_axi_kernel: vector-add kernel. Reads LEN beats from SRC over m0 in
// INCR bursts of up to MAX_BURST beats, adds ADDEND to every LANE_W lane and
// writes the result to DST. Programmed through the AXI-lite slave s0.
// Build option: define ADDER_AXI_SATURATE_EN for unsigned saturating lane adds
// (default wraps modulo 2^LANE_W).

module adder_axi_kernel #(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  adder_axi_kernel_m0_if.master m0,
  adder_axi_kernel_s0_if.slave  s0
);

  localparam int unsigned LANES   = DATA_W / LANE_W;
  localparam int unsigned SIZE_L2 = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned BEAT_W  = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
  } state_t;

  state_t              state;
  logic [63:0]         src, dst;
  logic [31:0]         len, addend, remaining;
  logic [ADDR_W-1:0]   cur_src, cur_dst;
  logic [BEAT_W-1:0]   beats;
  logic [IDX_W-1:0]    widx, ridx;
  logic                done, err;
  logic                ar_valid, aw_valid, w_valid, r_ready, b_ready;
  logic [DATA_W-1:0]   buffer [MAX_BURST];

  logic                s0_b_valid, s0_r_valid, s0_ar_ready;
  logic [31:0]         s0_r_data, rd_val;
  logic                wr_fire, rd_fire, idle, start_req, cfg_we, w_last;
  logic [3:0]          wr_sel, rd_sel;
  logic [31:0]         rem_next;
  logic [ADDR_W-1:0]   step;

  function automatic logic [BEAT_W-1:0] burst_beats(input logic [31:0] rem);
    if (rem >= 32'(MAX_BURST)) return BEAT_W'(MAX_BURST);
    return BEAT_W'(rem);
  endfunction

  function automatic logic [DATA_W-1:0] add_lanes(input logic [DATA_W-1:0] d,
                                                  input logic [LANE_W-1:0] a);
    logic [DATA_W-1:0] r;
`ifdef ADDER_AXI_SATURATE_EN
    logic [LANE_W:0]   s;
`endif
    r = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
`ifdef ADDER_AXI_SATURATE_EN
      s = {1'b0, d[i*LANE_W +: LANE_W]} + {1'b0, a};
      r[i*LANE_W +: LANE_W] = s[LANE_W] ? '1 : s[LANE_W-1:0];
`else
      r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W] + a;
`endif
    end
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // s0 decode and handshake conditions
  assign wr_fire   = s0.writeAddr_valid && s0.writeData_valid && !s0_b_valid;
  assign rd_fire   = s0.readAddr_valid && s0_ar_ready;
  assign wr_sel    = s0.writeAddr_bits_addr[5:2];
  assign rd_sel    = s0.readAddr_bits_addr[5:2];
  assign idle      = (state == S_IDLE) || (state == S_DONE);
  assign cfg_we    = wr_fire && idle;
  assign start_req = cfg_we && (wr_sel == 4'd0) && s0.writeData_bits_strb[0]
                     && s0.writeData_bits_data[0];

  assign s0.writeAddr_ready    = wr_fire;
  assign s0.writeData_ready    = wr_fire;
  assign s0.writeResp_valid    = s0_b_valid;
  assign s0.writeResp_bits     = 2'b00;
  assign s0.readAddr_ready     = s0_ar_ready;
  assign s0.readData_valid     = s0_r_valid;
  assign s0.readData_bits_data = s0_r_data;
  assign s0.readData_bits_resp = 2'b00;

  // Register read mux
  always_comb begin
    rd_val = '0;
    case (rd_sel)
      4'd0:    rd_val = {28'b0, err, idle, done, 1'b0};
      4'd1:    rd_val = src[31:0];
      4'd2:    rd_val = src[63:32];
      4'd3:    rd_val = dst[31:0];
      4'd4:    rd_val = dst[63:32];
      4'd5:    rd_val = len;
      4'd6:    rd_val = addend;
      default: rd_val = '0;
    endcase
  end

  // m0 channel outputs, all driven from registers
  assign m0.readAddr_valid       = ar_valid;
  assign m0.readAddr_bits_addr   = cur_src;
  assign m0.readAddr_bits_size   = 3'(SIZE_L2);
  assign m0.readAddr_bits_len    = 8'(beats - BEAT_W'(1));
  assign m0.readAddr_bits_burst  = 2'b01;
  assign m0.readAddr_bits_id     = 1'b0;
  assign m0.readAddr_bits_lock   = 1'b0;
  assign m0.readAddr_bits_cache  = 4'b0011;
  assign m0.readAddr_bits_prot   = 3'b000;
  assign m0.readAddr_bits_qos    = 4'b0000;
  assign m0.readData_ready       = r_ready;

  assign m0.writeAddr_valid      = aw_valid;
  assign m0.writeAddr_bits_addr  = cur_dst;
  assign m0.writeAddr_bits_size  = 3'(SIZE_L2);
  assign m0.writeAddr_bits_len   = 8'(beats - BEAT_W'(1));
  assign m0.writeAddr_bits_burst = 2'b01;
  assign m0.writeAddr_bits_id    = 1'b0;
  assign m0.writeAddr_bits_lock  = 1'b0;
  assign m0.writeAddr_bits_cache = 4'b0011;
  assign m0.writeAddr_bits_prot  = 3'b000;
  assign m0.writeAddr_bits_qos   = 4'b0000;

  assign w_last                  = (BEAT_W'(ridx) == beats - BEAT_W'(1));
  assign m0.writeData_valid      = w_valid;
  assign m0.writeData_bits_data  = buffer[ridx];
  assign m0.writeData_bits_strb  = '1;
  assign m0.writeData_bits_last  = w_last;
  assign m0.writeResp_ready      = b_ready;

  assign rem_next = remaining - 32'(beats);
  assign step     = ADDR_W'(beats) << SIZE_L2;

  logic unused_sink;
  assign unused_sink = ^{m0.writeResp_bits_id, m0.readData_bits_id, s0.writeAddr_bits_prot,
                         s0.readAddr_bits_prot, s0.writeAddr_bits_addr, s0.readAddr_bits_addr};

  // s0 response channels: B after accepted write, R after accepted read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0_b_valid  <= 1'b0;
      s0_r_valid  <= 1'b0;
      s0_ar_ready <= 1'b0;
      s0_r_data   <= '0;
    end else begin
      if (wr_fire)                  s0_b_valid <= 1'b1;
      else if (s0.writeResp_ready)  s0_b_valid <= 1'b0;

      if (rd_fire) begin
        s0_r_valid  <= 1'b1;
        s0_ar_ready <= 1'b0;
        s0_r_data   <= rd_val;
      end else if (s0_r_valid) begin
        if (s0.readData_ready) begin
          s0_r_valid  <= 1'b0;
          s0_ar_ready <= 1'b1;
        end
      end else begin
        s0_ar_ready <= 1'b1;
      end
    end
  end

  // Beat buffer: each accepted read beat is stored already added
  always_ff @(posedge clock) begin
    if (state == S_RD_DATA && m0.readData_valid && r_ready)
      buffer[widx] <= add_lanes(m0.readData_bits_data, LANE_W'(addend));
  end

  // Config registers, status bits and the burst sequencing FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      addend    <= '0;
      remaining <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      beats     <= '0;
      widx      <= '0;
      ridx      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      ar_valid  <= 1'b0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      r_ready   <= 1'b0;
      b_ready   <= 1'b0;
    end else begin
      // Clear-on-read first; a done set later in this block takes priority.
      if (rd_fire && rd_sel == 4'd0) done <= 1'b0;

      if (cfg_we) begin
        case (wr_sel)
          4'd1: src[31:0]  <= merge(src[31:0],  s0.writeData_bits_data, s0.writeData_bits_strb);
          4'd2: src[63:32] <= merge(src[63:32], s0.writeData_bits_data, s0.writeData_bits_strb);
          4'd3: dst[31:0]  <= merge(dst[31:0],  s0.writeData_bits_data, s0.writeData_bits_strb);
          4'd4: dst[63:32] <= merge(dst[63:32], s0.writeData_bits_data, s0.writeData_bits_strb);
          4'd5: len        <= merge(len,        s0.writeData_bits_data, s0.writeData_bits_strb);
          4'd6: addend     <= merge(addend,     s0.writeData_bits_data, s0.writeData_bits_strb);
          default: ;
        endcase
      end

      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start_req) begin
            err <= 1'b0;
            if (len == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              remaining <= len;
              beats     <= burst_beats(len);
              cur_src   <= ADDR_W'(src);
              cur_dst   <= ADDR_W'(dst);
              ar_valid  <= 1'b1;
              state     <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (m0.readAddr_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            widx     <= '0;
            state    <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m0.readData_valid && r_ready) begin
            widx <= widx + IDX_W'(1);
            if (m0.readData_bits_resp != 2'b00) err <= 1'b1;
            if (m0.readData_bits_last) begin
              r_ready  <= 1'b0;
              aw_valid <= 1'b1;
              state    <= S_WR_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (m0.writeAddr_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            ridx     <= '0;
            state    <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (m0.writeData_ready) begin
            if (w_last) begin
              w_valid <= 1'b0;
              b_ready <= 1'b1;
              state   <= S_WR_RESP;
            end else begin
              ridx <= ridx + IDX_W'(1);
            end
          end
        end
        S_WR_RESP: begin
          if (m0.writeResp_valid) begin
            b_ready   <= 1'b0;
            if (m0.writeResp_bits_resp != 2'b00) err <= 1'b1;
            remaining <= rem_next;
            cur_src   <= cur_src + step;
            cur_dst   <= cur_dst + step;
            if (rem_next != '0) begin
              beats    <= burst_beats(rem_next);
              ar_valid <= 1'b1;
              state    <= S_RD_ADDR;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
